fm_state_ram: RTL and testbench
===============================

# fm_state_ram

Parametrised per-slot state store for the FM synthesis pipeline, generalising the fixed 32×26 feedback RAM. It has a registered pipeline port with write-first forwarding, a request/acknowledge bus port for CPU/debug access, and a hardware clear sequencer that zeroes all entries after reset or on command. It sits beside the FM operator pipeline, and the bus port connects to the audio register decoder.

## Interface
- WIDTH, 26, data bits per entry
- DEPTH, 32, number of entries; power of two, ≥ 2
- AW, $clog2(DEPTH), address width (derived; do not override)

- clk  in  1  system clock; everything is rising-edge
- reset  in  1  asynchronous, active-high reset
- clear_start  in  1  one-cycle request to zero the whole array
- busy  out  1  clear sequence in progress
- p_idx  in  AW  pipeline slot address
- p_wrdata  in  WIDTH  pipeline write data
- p_wren  in  1  pipeline write enable
- p_rddata  out  WIDTH  registered read of p_idx
- b_addr  in  AW  bus address
- b_wrdata  in  WIDTH  bus write data
- b_wren  in  1  bus op is a write (qualified by b_req)
- b_req  in  1  bus request; held until b_ack
- b_ack  out  1  one-cycle acknowledge
- b_rddata  out  WIDTH  bus read data, valid with b_ack

## Operation
- Storage is DEPTH×WIDTH distributed RAM with one write port and two asynchronous read ports (pipeline, bus). Contents are not reset; the clear sequencer initialises them.
- Write-port priority: clear sequencer, then p_wren, then accepted bus write. Only one write happens per cycle.
- Clear FSM has two states, IDLE and CLEAR, plus a counter cnt[AW-1:0].
  - IDLE to CLEAR: on clear_start; cnt is set to 0.
  - CLEAR: write 0 to mem[cnt] and increment cnt. When cnt == DEPTH-1, return to IDLE.
  - clear_start is ignored while in CLEAR.
  - busy = (state == CLEAR).
- Pipeline writes are dropped while busy. Pipeline reads continue and return the current contents, including zeroes already written.
- Bus accept condition: b_req & ~b_ack & ~busy & ~(b_wren & p_wren).
  - On accept, a write goes to mem[b_addr] and a read captures mem[b_addr].
  - b_ack pulses the next cycle.
  - A bus read never conflicts with a pipeline write, because the bus port has its own read port.
- Every read is write-first. If the cycle's effective write address equals p_idx, the p_rddata register loads the write data. The same rule applies to b_rddata and b_addr.
- Master rule: b_req may still be high during the b_ack cycle. In the cycle after b_ack, b_req must be low or present a new operation.

## Timing
- Reset values: state = CLEAR, cnt = 0, busy = 1, p_rddata = 0, b_ack = 0, b_rddata = 0. An automatic clear therefore runs after every reset.
- busy is high for exactly DEPTH cycles, starting from the reset release or from the edge that samples clear_start.
- p_rddata latency is 1 cycle: the value at edge n+1 reflects p_idx at edge n, with forwarding applied.
- Bus latency: b_ack comes 1 cycle after accept at minimum. Each cycle a write is blocked by p_wren adds 1 cycle. While busy, all bus operations stall.
- If reset asserts mid-clear or mid-bus-op, the FSM restarts CLEAR at cnt = 0 and any pending ack is lost. The master must reissue.
- If clear_start and p_wren occur in the same IDLE cycle, the pipeline write takes effect and clearing starts on the next cycle.

## Structure
- Shared package fm_pkg holds:
  - FM_NUM_SLOTS = 32
  - FM_FB_WIDTH = 26
  - clear-FSM state encoding: ST_IDLE = 1'b0, ST_CLEAR = 1'b1
- Sub-module fm_lutram_2r1w (params WIDTH, DEPTH) wraps the storage. It is a per-bit generate over dual-port distributed RAM primitives and exposes waddr/wdata/wren, raddr0/rdata0 and raddr1/rdata1 as asynchronous reads.
- The top level contains the FSM, write mux, forwarding and output registers.

## Test plan
- Reset release: busy is high for 32 cycles, then low. Reading all 32 slots through p_idx returns 0.
- Pipeline write then read (p_wren=1, p_idx=5, p_wrdata=26'h2ABCDEF): holding p_idx=5, p_rddata = 26'h2ABCDEF on the next edge (forwarded). A later read of slot 5 also returns it.
- Conflict: a bus write to addr 3 (data 26'h15) is presented while p_wren=1 for 2 cycles. b_ack arrives on the 3rd cycle after b_req, and a subsequent read of slot 3 returns 26'h15.
- Bus read during busy: b_req issued 4 cycles into clear_start. b_ack occurs only after busy falls, and b_rddata = 0.
- Mid-clear reset: assert reset at cycle 10 of a clear. After release busy is high for 32 more cycles, and every slot written before the clear reads 0.
- Parameter sweep: WIDTH=8, DEPTH=4. Clear takes 4 cycles, and writes of distinct values to slots 0..3 read back correctly on both ports.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared definitions for the FM synthesis pipeline.
//   FM_NUM_SLOTS : number of operator slots (default state-store depth)
//   FM_FB_WIDTH  : feedback word width (default state-store width)
//   clr_state_t  : clear-sequencer FSM state encoding
package fm_pkg;

  localparam int FM_NUM_SLOTS = 32;
  localparam int FM_FB_WIDTH  = 26;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/fm_lutram_2r1w.sv
// Distributed RAM with one synchronous write port and two asynchronous read
// ports, built as one DEPTH x 1 column per data bit. Contents are not reset.
//   clk            : write clock
//   waddr/wdata/wren : write port
//   raddr0/rdata0  : asynchronous read port 0
//   raddr1/rdata1  : asynchronous read port 1
module fm_lutram_2r1w #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wren,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [DEPTH-1:0] col;

    always_ff @(posedge clk) begin
      if (wren) col[waddr] <= wdata[b];
    end

    assign rdata0[b] = col[raddr0];
    assign rdata1[b] = col[raddr1];
  end

endmodule

// File: rtl/fm_state_ram.sv
// Per-slot state store for the FM pipeline.
//   clk, reset         : clock, async active-high reset
//   clear_start, busy  : start / status of the array clear sequence
//   p_idx, p_wrdata, p_wren, p_rddata : pipeline port (registered read)
//   b_addr, b_wrdata, b_wren, b_req, b_ack, b_rddata : req/ack bus port
// Write priority: clear sequencer, pipeline, bus. Reads are write-first.
module fm_state_ram
  import fm_pkg::*;
#(
  parameter int WIDTH = FM_FB_WIDTH,
  parameter int DEPTH = FM_NUM_SLOTS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_start,
  output logic             busy,
  input  logic [AW-1:0]    p_idx,
  input  logic [WIDTH-1:0] p_wrdata,
  input  logic             p_wren,
  output logic [WIDTH-1:0] p_rddata,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wrdata,
  input  logic             b_wren,
  input  logic             b_req,
  output logic             b_ack,
  output logic [WIDTH-1:0] b_rddata
);

  clr_state_t       state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic             b_accept;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd0, rd1;
  logic [WIDTH-1:0] p_fwd, b_fwd;

  assign busy = (state == ST_CLEAR);

  // A bus write colliding with a pipeline write waits; reads never collide.
  assign b_accept = b_req & ~b_ack & ~busy & ~(b_wren & p_wren);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clear_start) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (busy) begin
      we    = 1'b1;
      waddr = cnt;
    end else if (p_wren) begin
      we    = 1'b1;
      waddr = p_idx;
      wdata = p_wrdata;
    end else if (b_accept && b_wren) begin
      we    = 1'b1;
      waddr = b_addr;
      wdata = b_wrdata;
    end
  end

  fm_lutram_2r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .waddr  (waddr),
    .wdata  (wdata),
    .wren   (we),
    .raddr0 (p_idx),
    .rdata0 (rd0),
    .raddr1 (b_addr),
    .rdata1 (rd1)
  );

  assign p_fwd = (we && (waddr == p_idx))  ? wdata : rd0;
  assign b_fwd = (we && (waddr == b_addr)) ? wdata : rd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rddata <= '0;
      b_ack    <= 1'b0;
      b_rddata <= '0;
    end else begin
      p_rddata <= p_fwd;
      b_ack    <= b_accept;
      if (b_accept && !b_wren) b_rddata <= b_fwd;
    end
  end

endmodule

// File: tb/tb_fm_state_ram.sv
module tb_fm_state_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_start;
  logic        busy;
  logic [4:0]  p_idx;
  logic [25:0] p_wrdata;
  logic        p_wren;
  logic [25:0] p_rddata;
  logic [4:0]  b_addr;
  logic [25:0] b_wrdata;
  logic        b_wren;
  logic        b_req;
  logic        b_ack;
  logic [25:0] b_rddata;

  // small instance for the parameter sweep
  logic        s_reset;
  logic        s_clear_start;
  logic        s_busy;
  logic [1:0]  s_idx;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  s_rddata;
  logic [1:0]  s_baddr;
  logic [7:0]  s_bwrdata;
  logic        s_bwren;
  logic        s_breq;
  logic        s_back;
  logic [7:0]  s_brddata;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  fm_state_ram dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .busy        (busy),
    .p_idx       (p_idx),
    .p_wrdata    (p_wrdata),
    .p_wren      (p_wren),
    .p_rddata    (p_rddata),
    .b_addr      (b_addr),
    .b_wrdata    (b_wrdata),
    .b_wren      (b_wren),
    .b_req       (b_req),
    .b_ack       (b_ack),
    .b_rddata    (b_rddata)
  );

  fm_state_ram #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut_s (
    .clk         (clk),
    .reset       (s_reset),
    .clear_start (s_clear_start),
    .busy        (s_busy),
    .p_idx       (s_idx),
    .p_wrdata    (s_wrdata),
    .p_wren      (s_wren),
    .p_rddata    (s_rddata),
    .b_addr      (s_baddr),
    .b_wrdata    (s_bwrdata),
    .b_wren      (s_bwren),
    .b_req       (s_breq),
    .b_ack       (s_back),
    .b_rddata    (s_brddata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus op and wait (bounded) for b_ack; cyc = edges until ack.
  task automatic bus_op(input logic [4:0] a, input logic we, input logic [25:0] d,
                        output int cyc, output logic [25:0] rd);
    b_addr = a; b_wren = we; b_wrdata = d; b_req = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b_ack && cyc < 200);
    rd = b_rddata;
    b_req = 1'b0; b_wren = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    #2;
    nchecks++;
    if (busy !== 1'b1 || b_ack !== 1'b0 || p_rddata !== 26'h0 || b_rddata !== 26'h0) begin
      nerrors++;
      $display("FAIL reset_values busy=%b b_ack=%b p_rddata=%h b_rddata=%h (want 1 0 0 0)",
               busy, b_ack, p_rddata, b_rddata);
    end
    tick();
    reset = 1'b0;
    count_busy(n);
    nchecks++;
    if (n !== 32) begin
      nerrors++;
      $display("FAIL reset_busy_len got %0d want 32", n);
    end
    for (int i = 0; i < 32; i++) begin
      p_idx = 5'(i);
      tick();
      nchecks++;
      if (p_rddata !== 26'h0) begin
        nerrors++;
        $display("FAIL reset_clear_slot%0d got %h want 0", i, p_rddata);
      end
    end
  endtask

  task automatic test_pipe_write();
    p_idx = 5'd5; p_wrdata = 26'h2ABCDEF; p_wren = 1'b1;
    tick();
    p_wren = 1'b0;
    nchecks++;
    if (p_rddata !== 26'h2ABCDEF) begin
      nerrors++;
      $display("FAIL pipe_forward got %h want 2abcdef", p_rddata);
    end
    p_idx = 5'd6;
    tick();
    nchecks++;
    if (p_rddata !== 26'h0) begin
      nerrors++;
      $display("FAIL pipe_other_slot got %h want 0", p_rddata);
    end
    p_idx = 5'd5;
    tick();
    nchecks++;
    if (p_rddata !== 26'h2ABCDEF) begin
      nerrors++;
      $display("FAIL pipe_readback got %h want 2abcdef", p_rddata);
    end
  endtask

  task automatic test_bus_basic();
    int cyc;
    logic [25:0] rd;
    bus_op(5'd9, 1'b1, 26'h123456, cyc, rd);
    nchecks++;
    if (cyc !== 1) begin
      nerrors++;
      $display("FAIL bus_write_latency got %0d want 1", cyc);
    end
    tick();
    bus_op(5'd9, 1'b0, 26'h0, cyc, rd);
    nchecks++;
    if (cyc !== 1 || rd !== 26'h123456) begin
      nerrors++;
      $display("FAIL bus_read cyc=%0d data=%h want 1 123456", cyc, rd);
    end
    tick();
    // bus read of the slot the pipeline writes in the same cycle: forwarded
    p_idx = 5'd12; p_wrdata = 26'h3000001; p_wren = 1'b1;
    b_addr = 5'd12; b_wren = 1'b0; b_req = 1'b1;
    tick();
    p_wren = 1'b0; b_req = 1'b0;
    nchecks++;
    if (b_ack !== 1'b1 || b_rddata !== 26'h3000001) begin
      nerrors++;
      $display("FAIL bus_read_forward ack=%b data=%h want 1 3000001", b_ack, b_rddata);
    end
    tick();
  endtask

  task automatic test_conflict();
    int cyc;
    p_idx = 5'd7; p_wrdata = 26'h0ABCDE; p_wren = 1'b1;
    b_addr = 5'd3; b_wrdata = 26'h15; b_wren = 1'b1; b_req = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 2) p_wren = 1'b0;
    end while (!b_ack && cyc < 200);
    b_req = 1'b0; b_wren = 1'b0;
    nchecks++;
    if (cyc !== 3) begin
      nerrors++;
      $display("FAIL conflict_ack_cycle got %0d want 3", cyc);
    end
    p_idx = 5'd3;
    tick();
    nchecks++;
    if (p_rddata !== 26'h15) begin
      nerrors++;
      $display("FAIL conflict_slot3 got %h want 15", p_rddata);
    end
    p_idx = 5'd7;
    tick();
    nchecks++;
    if (p_rddata !== 26'h0ABCDE) begin
      nerrors++;
      $display("FAIL conflict_slot7 got %h want 0abcde", p_rddata);
    end
  endtask

  task automatic test_bus_busy();
    int cyc;
    logic [25:0] rd;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (3) tick();
    bus_op(5'd5, 1'b0, 26'h0, cyc, rd);
    nchecks++;
    if (cyc !== 30 || busy !== 1'b0) begin
      nerrors++;
      $display("FAIL busy_bus_ack cyc=%0d busy=%b want 30 0", cyc, busy);
    end
    nchecks++;
    if (rd !== 26'h0) begin
      nerrors++;
      $display("FAIL busy_bus_data got %h want 0", rd);
    end
    tick();
  endtask

  task automatic test_clear_cmd();
    int n;
    // clear_start together with a pipeline write: write lands, clear follows
    p_idx = 5'd20; p_wrdata = 26'h1555555; p_wren = 1'b1; clear_start = 1'b1;
    tick();
    p_wren = 1'b0; clear_start = 1'b0;
    nchecks++;
    if (busy !== 1'b1 || p_rddata !== 26'h1555555) begin
      nerrors++;
      $display("FAIL clear_with_write busy=%b data=%h want 1 1555555", busy, p_rddata);
    end
    n = 0;
    while (busy && n < 200) begin
      clear_start = (n == 5);
      p_wren = (n == 30);
      p_idx = 5'd2; p_wrdata = 26'h2222222;
      tick();
      n++;
    end
    clear_start = 1'b0; p_wren = 1'b0;
    nchecks++;
    if (n !== 32) begin
      nerrors++;
      $display("FAIL clear_restart_ignored len=%0d want 32", n);
    end
    p_idx = 5'd20;
    tick();
    nchecks++;
    if (p_rddata !== 26'h0) begin
      nerrors++;
      $display("FAIL clear_slot20 got %h want 0", p_rddata);
    end
    p_idx = 5'd2;
    tick();
    nchecks++;
    if (p_rddata !== 26'h0) begin
      nerrors++;
      $display("FAIL busy_write_dropped got %h want 0", p_rddata);
    end
  endtask

  task automatic test_mid_clear_reset();
    int n;
    p_wren = 1'b1;
    p_idx = 5'd1; p_wrdata = 26'h1111111; tick();
    p_idx = 5'd2; p_wrdata = 26'h2222222; tick();
    p_wren = 1'b0;
    p_idx = 5'd1;
    tick();
    nchecks++;
    if (p_rddata !== 26'h1111111) begin
      nerrors++;
      $display("FAIL preclear_slot1 got %h want 1111111", p_rddata);
    end
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (10) tick();
    b_addr = 5'd4; b_wren = 1'b0; b_req = 1'b1;
    reset = 1'b1;
    #2;
    b_req = 1'b0;
    nchecks++;
    if (busy !== 1'b1 || b_ack !== 1'b0 || p_rddata !== 26'h0) begin
      nerrors++;
      $display("FAIL midreset_values busy=%b ack=%b data=%h want 1 0 0", busy, b_ack, p_rddata);
    end
    tick();
    reset = 1'b0;
    count_busy(n);
    nchecks++;
    if (n !== 32) begin
      nerrors++;
      $display("FAIL midreset_busy_len got %0d want 32", n);
    end
    for (int i = 1; i <= 2; i++) begin
      p_idx = 5'(i);
      tick();
      nchecks++;
      if (p_rddata !== 26'h0) begin
        nerrors++;
        $display("FAIL midreset_slot%0d got %h want 0", i, p_rddata);
      end
    end
  endtask

  task automatic test_param_sweep();
    int n;
    logic [7:0] vals [4];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF; vals[3] = 8'h81;
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    n = 0;
    while (s_busy && n < 50) begin
      tick();
      n++;
    end
    nchecks++;
    if (n !== 4) begin
      nerrors++;
      $display("FAIL sweep_busy_len got %0d want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      s_idx = 2'(i); s_wrdata = vals[i]; s_wren = 1'b1;
      tick();
    end
    s_wren = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_idx = 2'(3 - i);
      tick();
      nchecks++;
      if (s_rddata !== vals[3 - i]) begin
        nerrors++;
        $display("FAIL sweep_pipe_slot%0d got %h want %h", 3 - i, s_rddata, vals[3 - i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      s_baddr = 2'(i); s_bwren = 1'b0; s_breq = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!s_back && n < 50);
      s_breq = 1'b0;
      nchecks++;
      if (n !== 1 || s_brddata !== vals[i]) begin
        nerrors++;
        $display("FAIL sweep_bus_slot%0d cyc=%0d data=%h want 1 %h", i, n, s_brddata, vals[i]);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; clear_start = 1'b0;
    p_idx = '0; p_wrdata = '0; p_wren = 1'b0;
    b_addr = '0; b_wrdata = '0; b_wren = 1'b0; b_req = 1'b0;
    s_reset = 1'b0; s_clear_start = 1'b0;
    s_idx = '0; s_wrdata = '0; s_wren = 1'b0;
    s_baddr = '0; s_bwrdata = '0; s_bwren = 1'b0; s_breq = 1'b0;
    #1;
    test_reset();
    test_pipe_write();
    test_bus_basic();
    test_conflict();
    test_bus_busy();
    test_clear_cmd();
    test_mid_clear_reset();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
